tpu_bank_req_queue: RTL and testbench

Per-requestor request FIFO that sits directly upstream of the TPU bank arbiter; one instance per arbiter requestor slot (DMA, CPU, systolic, diagnostic).
- Buffers incoming memory requests and presents the head entry as the arbiter's req_valid/req_addr/req_write/req_priority.
- Holds the head across stall cycles and pops it on grant.
- Ages a stalled head and escalates its priority to 3 to bound starvation under round-robin.

---
 rtl/tpu_mem_pkg.sv | 26 ++
 rtl/tpu_req_fifo.sv | 69 ++++++
 rtl/tpu_bank_req_queue.sv | 147 ++++++++++++++
 tb/tb_tpu_bank_req_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_mem_pkg
// Purpose  : Shared types and constants for the TPU bank request path.
//            tpu_mem_req_t is one stored request. Its fields are sized for the
//            widest supported address and data. Instances with narrower
//            ADDR_WIDTH/DATA_WIDTH zero-extend into these fields.
// Revision : 1.0 - initial release
// ============================================================================
package tpu_mem_pkg;

  localparam int          TPU_ADDR_W = 16;    // widest supported ADDR_WIDTH
  localparam int          TPU_DATA_W = 32;    // widest supported DATA_WIDTH
  localparam logic [1:0]  PRIO_HIGH  = 2'b11;
  localparam int          AGE_W      = 8;

  // 'priority' is a reserved word, so the priority field is named prio.
  typedef struct packed {
    logic [TPU_ADDR_W-1:0] addr;
    logic                  write;
    logic [TPU_DATA_W-1:0] wdata;
    logic [1:0]            prio;
  } tpu_mem_req_t;

endpackage
`default_nettype wire

// File: rtl/tpu_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tpu_req_fifo
// Purpose  : Synchronous FIFO of tpu_mem_req_t. Full and empty are derived
//            from the occupancy count, not from pointer equality.
// Ports    : clk, rst (sync, active-high)
//            push_i / push_data_i : write one entry; ignored when full
//            pop_i                : drop the head; ignored when empty
//            head_o               : entry at the read pointer (raw storage)
//            count_o, full_o, empty_o : occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module tpu_req_fifo
  import tpu_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  tpu_mem_req_t     push_data_i,
  input  logic             pop_i,
  output tpu_mem_req_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  tpu_mem_req_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tpu_bank_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tpu_bank_req_queue
// Purpose  : Per-requestor request queue in front of the TPU bank arbiter.
//            - Presents the head request to the arbiter.
//            - Pops the head on grant.
//            - Ages a stalled head. Once the age reaches AGE_THRESH, the
//              head's effective priority is raised to PRIO_HIGH.
// Ports    : in_*           upstream request channel (valid/ready)
//            req_*, grant   arbiter-side head presentation and grant
//            occupancy      entries currently stored
//            escalations    heads escalated by aging (wraps at 2^32)
//            protocol_err   sticky; set when grant arrives with no head
//            clear_counters zeroes escalations and protocol_err
// Config   : define TPU_REQQ_BYPASS_EN to let an input request reach req_*
//            combinationally when the queue is empty (0-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module tpu_bank_req_queue
  import tpu_mem_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AGE_THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic                     in_write,
  input  logic [DATA_WIDTH-1:0]    in_wdata,
  input  logic [1:0]               in_priority,
  output logic                     req_valid,
  output logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     req_write,
  output logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [1:0]               req_priority,
  input  logic                     grant,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              escalations,
  output logic                     protocol_err,
  input  logic                     clear_counters
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  tpu_mem_req_t     w_in_req;
  tpu_mem_req_t     w_head;
  tpu_mem_req_t     w_req;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_bypass;
  logic             w_req_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_stall;
  logic             w_esc_event;

  logic [AGE_W-1:0] age_q, age_d;
  logic [31:0]      esc_q, esc_d;
  logic             perr_q, perr_d;

  always_comb begin
    w_in_req       = '0;
    w_in_req.addr  = TPU_ADDR_W'(in_addr);
    w_in_req.write = in_write;
    w_in_req.wdata = TPU_DATA_W'(in_wdata);
    w_in_req.prio  = in_priority;
  end

`ifdef TPU_REQQ_BYPASS_EN
  assign w_bypass = w_empty && in_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_req_valid = !w_empty || w_bypass;
  // Fields read 0 while nothing is presented.
  assign w_req       = !w_empty ? w_head : (w_bypass ? w_in_req : '0);
  assign w_pop       = grant && w_req_valid;
  // A bypassed request granted in the same cycle is consumed, never stored.
  assign w_push      = in_valid && in_ready && !(w_bypass && grant);

  tpu_req_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_in_req),
    .pop_i       (w_pop && !w_empty),
    .head_o      (w_head),
    .count_o     (w_count),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  // Only a stored head ages. A bypassed request is treated as age 0.
  assign w_stall     = !w_empty && !grant;
  assign w_esc_event = w_stall && (age_q == AGE_W'(AGE_THRESH - 1)) &&
                       (w_head.prio != PRIO_HIGH);

  always_comb begin
    age_d = age_q;
    if (w_empty || grant) begin
      age_d = '0;
    end else if (age_q != '1) begin
      age_d = age_q + AGE_W'(1);
    end

    esc_d  = esc_q + {31'd0, w_esc_event};
    perr_d = perr_q || (grant && !w_req_valid);
    if (clear_counters) begin
      esc_d  = '0;
      perr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q  <= '0;
      esc_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      age_q  <= age_d;
      esc_q  <= esc_d;
      perr_q <= perr_d;
    end
  end

  assign in_ready     = !w_full;
  assign occupancy    = w_count;
  assign req_valid    = w_req_valid;
  assign req_addr     = w_req.addr[ADDR_WIDTH-1:0];
  assign req_write    = w_req.write;
  assign req_wdata    = w_req.wdata[DATA_WIDTH-1:0];
  assign req_priority = (!w_empty && (age_q >= AGE_W'(AGE_THRESH))) ? PRIO_HIGH
                                                                    : w_req.prio;
  assign escalations  = esc_q;
  assign protocol_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_tpu_bank_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_bank_req_queue
// Purpose  : Self-checking bench for tpu_bank_req_queue. Directed stimulus
//            pushes the expected granted request into a scoreboard queue. A
//            monitor compares each arbiter-side pop against the scoreboard.
//            Status outputs are checked directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_bank_req_queue;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [1:0]  prio;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic        in_write;
  logic [31:0] in_wdata;
  logic [1:0]  in_priority;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  req_priority;
  logic        grant;
  logic [2:0]  occupancy;
  logic [31:0] escalations;
  logic        protocol_err;
  logic        clear_counters;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  tpu_bank_req_queue #(
    .DEPTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .AGE_THRESH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_write(in_write), .in_wdata(in_wdata), .in_priority(in_priority),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_priority(req_priority), .grant(grant),
    .occupancy(occupancy), .escalations(escalations),
    .protocol_err(protocol_err), .clear_counters(clear_counters)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive request i. Its fields are derived from i, so the expected record
  // can be rebuilt independently.
  function automatic exp_t mk(input int i, input logic [1:0] p);
    exp_t e;
    e.addr  = 16'h0100 + 16'(i);
    e.write = 1'(i & 1);
    e.wdata = 32'h01010101 * 32'(i);
    e.prio  = p;
    return e;
  endfunction

  task automatic drive(input exp_t e);
    in_valid    = 1'b1;
    in_addr     = e.addr;
    in_write    = e.write;
    in_wdata    = e.wdata;
    in_priority = e.prio;
  endtask

  // Monitor: every arbiter pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && req_valid && grant) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: addr=%0h with empty scoreboard", req_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_fields", {13'd0, req_addr, req_write, req_wdata, req_priority},
            {13'd0, e.addr, e.write, e.wdata, e.prio});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; in_valid = 0; in_addr = 0; in_write = 0; in_wdata = 0;
    in_priority = 0; grant = 0; clear_counters = 0;
    repeat (2) tick();
    rst = 1'b0;
    // Reset state.
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_req_valid", 64'(req_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_esc", 64'(escalations), 0);
    chk("rst_perr", 64'(protocol_err), 0);
    chk("rst_head_zero", {29'd0, req_addr, req_write, req_priority}, 0);

    // Single read into an empty queue: visible next cycle, then granted.
    e = '{addr: 16'h0013, write: 1'b0, wdata: 32'h0, prio: 2'd1};
    drive(e); sb.push_back(e);
`ifndef TPU_REQQ_BYPASS_EN
    chk("lat_same_cycle_invalid", 64'(req_valid), 0);
`endif
    tick(); in_valid = 0;
    chk("lat_req_valid", 64'(req_valid), 1);
    chk("lat_addr_prio", {req_addr, req_priority}, {16'h0013, 2'd1});
    grant = 1; tick(); grant = 0;
    chk("pop_occ0", 64'(occupancy), 0);
    chk("pop_req_valid0", 64'(req_valid), 0);

    // Fill to DEPTH, refuse a 5th push, then check full push+pop behaviour.
    for (int i = 1; i <= 4; i++) begin
      e = mk(i, 2'(i)); drive(e); sb.push_back(e); tick();
    end
    in_valid = 0;
    chk("full_in_ready", 64'(in_ready), 0);
    chk("full_occ", 64'(occupancy), 4);
    e = mk(5, 2'd1); drive(e); tick();
    chk("full_refuse", 64'(occupancy), 4);
    grant = 1; tick();              // push refused, pop 1 -> 3
    chk("full_push_pop", 64'(occupancy), 3);
    grant = 0; sb.push_back(e); tick();   // 5 accepted now
    in_valid = 0;
    chk("refill_occ", 64'(occupancy), 4);
    grant = 1; repeat (2) tick();   // pop 2,3
    chk("drain_occ2", 64'(occupancy), 2);
    e = mk(6, 2'd2); drive(e); sb.push_back(e); tick(); // pop 4, push 6
    in_valid = 0;
    chk("pushpop_occ2", 64'(occupancy), 2);
    repeat (2) tick();              // pop 5,6
    grant = 0;
    chk("drain_occ0", 64'(occupancy), 0);

    // Aging: prio-0 head stalls until escalated, next head keeps base prio.
    e = mk(8'h20, 2'd0); drive(e); e.prio = 2'd3; sb.push_back(e); tick();
    e = mk(8'h21, 2'd2); drive(e); sb.push_back(e); tick();
    in_valid = 0;                   // head age is 1 here
    for (int k = 1; k < 8; k++) begin
      chk("age_base_prio", 64'(req_priority), 0);
      tick();
    end
    chk("age_escalated", 64'(req_priority), 3);
    chk("esc_once", 64'(escalations), 1);
    repeat (3) tick();
    chk("esc_stays", 64'(escalations), 1);
    grant = 1; tick(); grant = 0;
    chk("next_head_base", 64'(req_priority), 2);
    grant = 1; tick(); grant = 0;

    // A head already at prio 3 is not counted.
    e = mk(8'h30, 2'd3); drive(e); sb.push_back(e); tick();
    in_valid = 0; repeat (10) tick();
    chk("esc_prio3_nocount", 64'(escalations), 1);
    grant = 1; tick(); grant = 0;

    // Grant while empty, then clear_counters with a queued entry.
    grant = 1; tick(); grant = 0;
    chk("perr_set", 64'(protocol_err), 1);
    chk("perr_occ", 64'(occupancy), 0);
    e = mk(8'h40, 2'd1); drive(e); sb.push_back(e); tick(); in_valid = 0;
    clear_counters = 1; tick(); clear_counters = 0;
    chk("clr_perr", 64'(protocol_err), 0);
    chk("clr_esc", 64'(escalations), 0);
    chk("clr_occ_kept", 64'(occupancy), 1);
    grant = 1; tick(); grant = 0;

    // Request with grant in the same cycle into an empty queue.
    e = mk(8'h50, 2'd1); drive(e); grant = 1; sb.push_back(e);
`ifdef TPU_REQQ_BYPASS_EN
    chk("byp_same_cycle", 64'(req_valid), 1);
    tick(); in_valid = 0; grant = 0;
    chk("byp_occ0", 64'(occupancy), 0);
`else
    chk("nobyp_same_cycle", 64'(req_valid), 0);
    tick(); in_valid = 0;
    chk("nobyp_next_valid", 64'(req_valid), 1);
    tick(); grant = 0;
    chk("nobyp_occ0", 64'(occupancy), 0);
`endif

    // Reset mid-operation drops entries and ignores a coincident grant.
    drive(mk(8'h60, 2'd0)); tick();
    drive(mk(8'h61, 2'd0)); tick(); in_valid = 0;
    rst = 1; grant = 1; tick(); rst = 0; grant = 0;
    chk("midrst_occ", 64'(occupancy), 0);
    chk("midrst_valid", 64'(req_valid), 0);

    tick();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
